// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide step per cycle,
// fixed 32-iteration latency for every operation, result registered on entry to DONE.
module mul_div_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            RST,
   input  logic            MD_START,
   input  logic [2:0]      MD_FUNCT3,
   input  logic [XLEN-1:0] MD_RS1,
   input  logic [XLEN-1:0] MD_RS2,
   output logic            MD_BUSY,
   output logic            MD_DONE,
   output logic [XLEN-1:0] MD_RESULT
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [2:0]  op_q, op_d;
   logic        neg_a_q, neg_a_d;
   logic        neg_b_q, neg_b_d;
   logic        dz_q, dz_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [63:0] acc_q, acc_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [31:0] result_q, result_d;

   logic        sign_a, sign_b;
   logic [32:0] mul_sum;
   logic [32:0] div_shift;
   logic [32:0] div_diff;
   logic [63:0] prod;

   function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
      return neg ? (32'd0 - v) : v;
   endfunction

   function automatic logic [63:0] cond_neg64(input logic [63:0] v, input logic neg);
      return neg ? (64'd0 - v) : v;
   endfunction

   // State register
   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  state_d = MD_START ? S_CALC : S_IDLE;
         S_CALC:  state_d = (cnt_q == 5'd31) ? S_DONE : S_CALC;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Operand capture and one iteration step per CALC cycle
   always_comb begin
      sign_a    = (MD_FUNCT3 != 3'd3) && (MD_FUNCT3 != 3'd5) && (MD_FUNCT3 != 3'd7);
      sign_b    = (MD_FUNCT3 == 3'd0) || (MD_FUNCT3 == 3'd1) ||
                  (MD_FUNCT3 == 3'd4) || (MD_FUNCT3 == 3'd6);
      mul_sum   = {1'b0, acc_q[63:32]} + {1'b0, (b_q[0] ? a_q : 32'd0)};
      div_shift = {acc_q[31:0], b_q[31]};
      div_diff  = div_shift - {1'b0, a_q};
      cnt_d     = cnt_q;
      op_d      = op_q;
      neg_a_d   = neg_a_q;
      neg_b_d   = neg_b_q;
      dz_d      = dz_q;
      a_d       = a_q;
      b_d       = b_q;
      acc_d     = acc_q;
      if ((state_q == S_IDLE) && MD_START) begin
         op_d    = MD_FUNCT3;
         neg_a_d = sign_a & MD_RS1[31];
         neg_b_d = sign_b & MD_RS2[31];
         dz_d    = (MD_RS2 == 32'd0);
         cnt_d   = 5'd0;
         acc_d   = 64'd0;
         // Multiply keeps the multiplier in b; divide shifts the dividend out of b as quotient fills in.
         if (MD_FUNCT3[2]) begin
            a_d = cond_neg32(MD_RS2, sign_b & MD_RS2[31]);
            b_d = cond_neg32(MD_RS1, sign_a & MD_RS1[31]);
         end else begin
            a_d = cond_neg32(MD_RS1, sign_a & MD_RS1[31]);
            b_d = cond_neg32(MD_RS2, sign_b & MD_RS2[31]);
         end
      end else if (state_q == S_CALC) begin
         cnt_d = cnt_q + 5'd1;
         if (!op_q[2]) begin
            acc_d = {mul_sum, acc_q[31:1]};
            b_d   = {1'b0, b_q[31:1]};
         end else if (!div_diff[32]) begin
            acc_d = {31'd0, div_diff};
            b_d   = {b_q[30:0], 1'b1};
         end else begin
            acc_d = {31'd0, div_shift};
            b_d   = {b_q[30:0], 1'b0};
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Output logic: flags follow the next state, result formed from the final iteration
   always_comb begin
      busy_d   = (state_d == S_CALC);
      done_d   = (state_d == S_DONE);
      result_d = result_q;
      prod     = cond_neg64(acc_d, neg_a_q ^ neg_b_q);
      if ((state_q == S_CALC) && (state_d == S_DONE)) begin
         case (op_q)
            3'd0:          result_d = prod[31:0];
            3'd1, 3'd2, 3'd3: result_d = prod[63:32];
            3'd4, 3'd5:    result_d = dz_q ? 32'hFFFF_FFFF : cond_neg32(b_d, neg_a_q ^ neg_b_q);
            3'd6, 3'd7:    result_d = cond_neg32(acc_d[31:0], neg_a_q);
            default:       result_d = 32'd0;
         endcase
      end else begin
         result_d = result_q;
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         cnt_q    <= 5'd0;
         op_q     <= 3'd0;
         neg_a_q  <= 1'b0;
         neg_b_q  <= 1'b0;
         dz_q     <= 1'b0;
         a_q      <= 32'd0;
         b_q      <= 32'd0;
         acc_q    <= 64'd0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= 32'd0;
      end else begin
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         neg_a_q  <= neg_a_d;
         neg_b_q  <= neg_b_d;
         dz_q     <= dz_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
      end
   end

   assign MD_BUSY   = busy_q;
   assign MD_DONE   = done_q;
   assign MD_RESULT = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: timeline model plus arithmetic reference, directed and random ops.
module tb_mul_div_unit;

   logic        clk = 1'b0;
   logic        RST = 1'b1;
   logic        MD_START = 1'b0;
   logic [2:0]  MD_FUNCT3 = 3'd0;
   logic [31:0] MD_RS1 = 32'd0;
   logic [31:0] MD_RS2 = 32'd0;
   logic        MD_BUSY;
   logic        MD_DONE;
   logic [31:0] MD_RESULT;

   int total = 0;
   int bad   = 0;

   mul_div_unit #(.XLEN(32)) dut (
      .clk(clk), .RST(RST), .MD_START(MD_START), .MD_FUNCT3(MD_FUNCT3),
      .MD_RS1(MD_RS1), .MD_RS2(MD_RS2),
      .MD_BUSY(MD_BUSY), .MD_DONE(MD_DONE), .MD_RESULT(MD_RESULT)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Arithmetic reference from the RV32M definitions
   function automatic logic [31:0] ref_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] ea, eb, p;
      int sq;
      if (op <= 3'd3) begin
         ea = (op != 3'd3) ? {{32{a[31]}}, a} : {32'd0, a};
         eb = (op <= 3'd1) ? {{32{b[31]}}, b} : {32'd0, b};
         p  = ea * eb;
         return (op == 3'd0) ? p[31:0] : p[63:32];
      end
      if (b == 32'd0) return (op == 3'd4 || op == 3'd5) ? 32'hFFFF_FFFF : a;
      if (op == 3'd5) return a / b;
      if (op == 3'd7) return a % b;
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return (op == 3'd4) ? 32'h8000_0000 : 32'd0;
      sq = (op == 3'd4) ? ($signed(a) / $signed(b)) : ($signed(a) % $signed(b));
      return sq;
   endfunction

   // Timeline model: accept in idle, 32 busy cycles, one done cycle, result held
   logic        exp_busy = 1'b0;
   logic        exp_done = 1'b0;
   logic [31:0] exp_result = 32'd0;
   logic [31:0] pend = 32'd0;
   int          left = 0;

   always @(posedge clk or posedge RST) begin
      if (RST) begin
         exp_busy   <= 1'b0;
         exp_done   <= 1'b0;
         exp_result <= 32'd0;
         left       <= 0;
      end else if (exp_busy) begin
         if (left == 1) begin
            exp_busy   <= 1'b0;
            exp_done   <= 1'b1;
            exp_result <= pend;
         end
         left <= left - 1;
      end else if (exp_done) begin
         exp_done <= 1'b0;
      end else if (MD_START) begin
         exp_busy <= 1'b1;
         left     <= 32;
         pend     <= ref_fn(MD_FUNCT3, MD_RS1, MD_RS2);
      end
   end

   // Cycle-by-cycle compare of DUT against the model
   always @(negedge clk) begin
      check("busy", {31'd0, MD_BUSY}, {31'd0, exp_busy});
      check("done", {31'd0, MD_DONE}, {31'd0, exp_done});
      check("result", MD_RESULT, exp_result);
   end

   task automatic wait_done(input string name);
      logic got;
      got = 1'b0;
      for (int i = 0; i < 45 && !got; i++) begin
         @(negedge clk);
         if (MD_DONE) got = 1'b1;
      end
      check({name, "_timeout"}, {31'd0, got}, 32'd1);
   endtask

   task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] lit);
      @(negedge clk);
      MD_FUNCT3 = op; MD_RS1 = a; MD_RS2 = b; MD_START = 1'b1;
      @(negedge clk);
      MD_START = 1'b0;
      wait_done(name);
      check(name, MD_RESULT, lit);
      check({name, "_model"}, ref_fn(op, a, b), lit);
   endtask

   function automatic logic [31:0] rnd_val();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic seen;
      @(negedge clk);
      check("rst_busy", {31'd0, MD_BUSY}, 32'd0);
      check("rst_done", {31'd0, MD_DONE}, 32'd0);
      check("rst_result", MD_RESULT, 32'd0);
      RST = 1'b0;

      run_op("mul_neg", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
      @(negedge clk);
      check("hold_after_done", MD_RESULT, 32'hFFFF_FFEB);
      run_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
      run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF);
      run_op("div_neg", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
      run_op("rem_neg", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
      run_op("divu", 3'd5, 32'd100, 32'd7, 32'd14);
      run_op("remu", 3'd7, 32'd100, 32'd7, 32'd2);
      run_op("divu_z", 3'd5, 32'h1234, 32'd0, 32'hFFFF_FFFF);
      run_op("rem_z", 3'd6, 32'h1234, 32'd0, 32'h1234);
      run_op("div_z_neg", 3'd4, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FFFF);
      run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
      run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

      // Inputs and MD_START during CALC must be ignored
      @(negedge clk);
      MD_FUNCT3 = 3'd0; MD_RS1 = 32'd3; MD_RS2 = 32'd5; MD_START = 1'b1;
      @(negedge clk);
      MD_START = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         MD_FUNCT3 = 3'($urandom); MD_RS1 = $urandom; MD_RS2 = $urandom;
         MD_START = i[0];
      end
      MD_START = 1'b0;
      wait_done("ignore");
      check("ignore", MD_RESULT, 32'd15);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (MD_BUSY || MD_DONE) seen = 1'b1;
      end
      check("no_second_op", {31'd0, seen}, 32'd0);

      // Reset in the middle of a divide
      @(negedge clk);
      MD_FUNCT3 = 3'd5; MD_RS1 = 32'd1000; MD_RS2 = 32'd3; MD_START = 1'b1;
      @(negedge clk);
      MD_START = 1'b0;
      repeat (9) @(negedge clk);
      #2 RST = 1'b1;
      #1;
      check("abort_busy", {31'd0, MD_BUSY}, 32'd0);
      check("abort_done", {31'd0, MD_DONE}, 32'd0);
      check("abort_result", MD_RESULT, 32'd0);
      @(negedge clk);
      RST = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (MD_DONE) seen = 1'b1;
      end
      check("no_done_after_abort", {31'd0, seen}, 32'd0);
      run_op("after_abort", 3'd5, 32'd1000, 32'd3, 32'd333);

      // MD_START held high: back-to-back ops with operands changed at each done
      @(negedge clk);
      MD_FUNCT3 = 3'd0; MD_RS1 = 32'd6; MD_RS2 = 32'd7; MD_START = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wait_done("held");
         MD_FUNCT3 = 3'($urandom); MD_RS1 = rnd_val(); MD_RS2 = rnd_val();
      end
      MD_START = 1'b0;
      repeat (40) @(negedge clk);

      // Random ops; the compare process checks every cycle
      for (int n = 0; n < 150; n++) begin
         @(negedge clk);
         MD_FUNCT3 = 3'($urandom); MD_RS1 = rnd_val(); MD_RS2 = rnd_val(); MD_START = 1'b1;
         @(negedge clk);
         MD_START = 1'b0;
         wait_done("rand");
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
